// File: rtl/pipe_stage_chain.sv
// Generic in-order pipeline register chain with per-stage valid bits.
// It also handles stall/bubble insertion, younger-stage flush, downstream backpressure and saturating perf counters.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    input  logic [WIDTH-1:0]                              in_data,
    output logic                                          in_ready,
    input  logic [STAGES-1:0]                             stall_req,
    input  logic                                          flush_req,
    input  logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] flush_stage,
    output logic                                          out_valid,
    output logic [WIDTH-1:0]                              out_data,
    input  logic                                          out_ready,
    output logic [STAGES-1:0]                             stage_valid,
    output logic [STAGES*WIDTH-1:0]                       stage_data,
    input  logic                                          clr_cnt,
    output logic [15:0]                                   stall_cycles,
    output logic [15:0]                                   flush_count
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [15:0]       stall_cycles_q;
    logic [15:0]       stall_cycles_d;
    logic [15:0]       flush_count_q;
    logic [15:0]       flush_count_d;

    logic [STAGES-1:0] hold_vec;
    logic              any_hold;
    logic              flush_ok;
    int                hold_top;
    logic [STAGES-1:0] feed_valid;
    logic [WIDTH-1:0]  feed_data [STAGES];

    // Backpressure acts as a hold request on the oldest stage.
    always_comb begin
        hold_vec           = stall_req;
        hold_vec[STAGES-1] = stall_req[STAGES-1] | (valid_q[STAGES-1] & ~out_ready);
        any_hold           = |hold_vec;
        hold_top           = -1;
        for (int i = 0; i < STAGES; i++) begin
            if (hold_vec[i]) begin
                hold_top = i;
            end
        end
        flush_ok = flush_req && (int'(flush_stage) >= 1) && (int'(flush_stage) <= STAGES - 1);
    end

    assign in_ready = !any_hold && !flush_ok;

    always_comb begin
        feed_valid[0] = in_valid && in_ready;
        feed_data[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            feed_valid[i] = valid_q[i-1];
            feed_data[i]  = data_q[i-1];
        end
    end

    // Flush kill is applied last so it overrides hold and bubble.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
            if (any_hold && (i <= hold_top)) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
            end else if (!(any_hold && (i == hold_top + 1))) begin
                valid_d[i] = feed_valid[i];
                data_d[i]  = feed_data[i];
            end
            if (flush_ok && (i < int'(flush_stage))) begin
                valid_d[i] = 1'b0;
            end
            if (!valid_d[i]) begin
                data_d[i] = '0;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (clr_cnt) begin
            stall_cycles_d = '0;
            flush_count_d  = '0;
        end else begin
            if (any_hold && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_d = stall_cycles_q + 16'd1;
            end
            if (flush_ok && (flush_count_q != 16'hFFFF)) begin
                flush_count_d = flush_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    assign out_valid    = valid_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign stage_valid  = valid_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed testbench for pipe_stage_chain (WIDTH=32, STAGES=5).
// Expected output payloads go into a queue; a negedge monitor pops and compares every output transfer.
module tb_pipe_stage_chain;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [4:0]   stall_req;
    logic         flush_req;
    logic [2:0]   flush_stage;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready;
    logic [4:0]   stage_valid;
    logic [159:0] stage_data;
    logic         clr_cnt;
    logic [15:0]  stall_cycles;
    logic [15:0]  flush_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    pipe_stage_chain #(.WIDTH(32), .STAGES(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall_req    (stall_req),
        .flush_req    (flush_req),
        .flush_stage  (flush_stage),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .clr_cnt      (clr_cnt),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] stall,
                                 input logic fr, input logic [2:0] fs);
        in_valid    = v;
        in_data     = d;
        stall_req   = stall;
        flush_req   = fr;
        flush_stage = fs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every output transfer must match the oldest outstanding expected payload.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_extra: got %0h, expected no output", out_data);
            end else begin
                logic [31:0] exp_val;
                exp_val = sb.pop_front();
                if (out_data !== exp_val) begin
                    errors++;
                    $display("[TB] FAIL sb_data: got %0h, expected %0h", out_data, exp_val);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stage_valid", 160'(stage_valid), 160'(0));
        checkOutput("rst_stage_data", stage_data, 160'(0));
        checkOutput("rst_out", 160'({out_valid, out_data}), 160'(0));
        checkOutput("rst_cnts", 160'({stall_cycles, flush_count}), 160'(0));
        checkOutput("rst_in_ready", 160'(in_ready), 160'(1));
        rst = 1'b0;

        $display("[TB] stream 1..10");
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 32'(k), 5'b0, 1'b0, 3'd0);
            sb.push_back(32'(k));
            tick();
            if (k == 4) checkOutput("lat_not_yet", 160'(out_valid), 160'(0));
            if (k == 5) checkOutput("lat_first", 160'({out_valid, out_data}), 160'({1'b1, 32'd1}));
        end
        checkOutput("stream_full", 160'(stage_valid), 160'(5'b11111));
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        repeat (6) tick();
        checkOutput("stream_drained", 160'(stage_valid), 160'(0));
        checkOutput("stream_stalls", 160'(stall_cycles), 160'(0));
        checkOutput("stream_sb_empty", 160'(sb.size()), 160'(0));

        $display("[TB] stall bubble");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'hA + 32'(k), 5'b0, 1'b0, 3'd0);
            sb.push_back(32'hA + 32'(k));
            tick();
        end
        applyStimulus(1'b1, 32'hF, 5'b00010, 1'b0, 3'd0);
        #1;
        checkOutput("stall_in_ready", 160'(in_ready), 160'(0));
        tick();
        checkOutput("stall_valid", 160'(stage_valid), 160'(5'b11011));
        checkOutput("stall_data", stage_data, {32'hB, 32'hC, 32'h0, 32'hD, 32'hE});
        checkOutput("stall_cnt", 160'(stall_cycles), 160'(1));
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        repeat (6) tick();
        checkOutput("stall_sb_empty", 160'(sb.size()), 160'(0));

        $display("[TB] flush");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'h11 + 32'(k), 5'b0, 1'b0, 3'd0);
            if (k < 4) sb.push_back(32'h11 + 32'(k));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b1, 3'd2);
        #1;
        checkOutput("flush_in_ready", 160'(in_ready), 160'(0));
        tick();
        checkOutput("flush_valid", 160'(stage_valid), 160'(5'b11100));
        checkOutput("flush_data", stage_data, {32'h12, 32'h13, 32'h14, 32'h0, 32'h0});
        checkOutput("flush_cnt", 160'(flush_count), 160'(1));
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b1, 3'd0);
        #1;
        checkOutput("flush0_in_ready", 160'(in_ready), 160'(1));
        tick();
        checkOutput("flush0_valid", 160'(stage_valid), 160'(5'b11000));
        checkOutput("flush0_cnt", 160'(flush_count), 160'(1));
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b1, 3'd7);
        #1;
        checkOutput("flush7_in_ready", 160'(in_ready), 160'(1));
        tick();
        checkOutput("flush7_data", stage_data, {32'h14, 128'h0});
        checkOutput("flush7_cnt", 160'(flush_count), 160'(1));
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        repeat (3) tick();
        checkOutput("flush_sb_empty", 160'(sb.size()), 160'(0));

        $display("[TB] flush with stall");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'h21 + 32'(k), 5'b0, 1'b0, 3'd0);
            if (k < 3) sb.push_back(32'h21 + 32'(k));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 5'b01000, 1'b1, 3'd2);
        tick();
        checkOutput("fs_valid", 160'(stage_valid), 160'(5'b01100));
        checkOutput("fs_data", stage_data, {32'h0, 32'h22, 32'h23, 64'h0});
        checkOutput("fs_cnts", 160'({stall_cycles, flush_count}), 160'({16'd2, 16'd2}));
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        repeat (6) tick();
        checkOutput("fs_sb_empty", 160'(sb.size()), 160'(0));

        $display("[TB] backpressure");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 32'h30 + 32'(k), 5'b0, 1'b0, 3'd0);
            sb.push_back(32'h30 + 32'(k));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checkOutput("bp_out", 160'({out_valid, out_data}), 160'({1'b1, 32'h31}));
            checkOutput("bp_in_ready", 160'(in_ready), 160'(0));
            tick();
        end
        checkOutput("bp_cnt", 160'(stall_cycles), 160'(5));
        checkOutput("bp_data", stage_data, {32'h31, 32'h32, 32'h33, 32'h34, 32'h35});
        out_ready = 1'b1;
        repeat (6) tick();
        checkOutput("bp_sb_empty", 160'(sb.size()), 160'(0));

        $display("[TB] counter saturation");
        applyStimulus(1'b0, 32'h0, 5'b00001, 1'b0, 3'd0);
        repeat (65540) @(posedge clk);
        #1;
        checkOutput("sat_cnt", 160'(stall_cycles), 160'(16'hFFFF));
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checkOutput("clr_cnts", 160'({stall_cycles, flush_count}), 160'(0));
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        tick();

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 32'h41, 5'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b1, 32'h42, 5'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 5'b00001, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 3'd0);
        checkOutput("mid_valid", 160'(stage_valid), 160'(5'b00101));
        checkOutput("mid_cnt", 160'(stall_cycles), 160'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 160'(stage_valid), 160'(0));
        checkOutput("mid_rst_data", stage_data, 160'(0));
        checkOutput("mid_rst_out", 160'({out_valid, out_data}), 160'(0));
        checkOutput("mid_rst_cnt", 160'({stall_cycles, flush_count}), 160'(0));
        tick();
        rst = 1'b0;
        repeat (2) tick();
        checkOutput("final_sb_empty", 160'(sb.size()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
